// File: rtl/bit_divider_8_pkg.sv
// Shared types and constants for the 8-bit restoring divider.
// Kept in its own package so the lab top level can reuse the state encoding.
package divider_pkg;

  localparam int N    = 8;
  localparam int ITER = N;
  localparam logic [N-1:0] DIVZERO_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/bit_divider_8_if.sv
// Run/Done style start-and-result bundle shared by the divider and its driver.
interface bit_divider_8_if;
  import divider_pkg::*;

  logic         Run;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Done;
  logic         DivZero;

  modport master (
    output Run, Dividend, Divisor,
    input  Quotient, Remainder, Done, DivZero
  );

  modport slave (
    input  Run, Dividend, Divisor,
    output Quotient, Remainder, Done, DivZero
  );
endinterface

// File: rtl/add_sub_9.sv
// 9-bit ripple add/subtract: Sum = A + (B ^ {9{Sub}}) + Sub, CO = carry out of bit 8.
module add_sub_9 (
  input  logic [8:0] A,
  input  logic [8:0] B,
  input  logic       Sub,
  output logic [8:0] Sum,
  output logic       CO
);

  logic [8:0] b_eff;
  logic [9:0] carry;

  assign b_eff    = B ^ {9{Sub}};
  assign carry[0] = Sub;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_fa
      assign Sum[gi]      = A[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1]  = (A[gi] & b_eff[gi]) | (carry[gi] & (A[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign CO = carry[9];

endmodule

// File: rtl/bit_divider_8.sv
// Unsigned 8/8 sequential restoring divider, one quotient bit per clock.
// Outputs update only on entry to DONE and hold until the next completion or Reset.
module bit_divider_8
  import divider_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  bit_divider_8_if.slave bus
);

  localparam int CW = $clog2(ITER);

  state_t        state_reg, state_next;
  logic [N-1:0]  r_reg, r_next;
  logic [N-1:0]  q_reg, q_next;
  logic [N-1:0]  m_reg, m_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  quotient_reg, quotient_next;
  logic [N-1:0]  remainder_reg, remainder_next;
  logic          div_zero_reg, div_zero_next;

  logic [N:0]    rs;
  logic [N:0]    diff;
  logic          co;
  logic          take;
  logic [N-1:0]  r_iter;
  logic [N-1:0]  q_iter;

  // R < M before every shift, so the upper bit of R is always zero and is not stored.
  assign rs = {r_reg, q_reg[N-1]};

  add_sub_9 u_add_sub (
    .A   (rs),
    .B   ({1'b0, m_reg}),
    .Sub (1'b1),
    .Sum (diff),
    .CO  (co)
  );

  // A successful subtract always fits in N bits; the extra term only documents that.
  assign take   = co & ~diff[N];
  assign r_iter = take ? diff[N-1:0] : rs[N-1:0];
  assign q_iter = {q_reg[N-2:0], take};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      m_reg         <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      r_reg         <= r_next;
      q_reg         <= q_next;
      m_reg         <= m_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      div_zero_reg  <= div_zero_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    r_next         = r_reg;
    q_next         = q_reg;
    m_next         = m_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    div_zero_next  = div_zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.Run) begin
          m_next     = bus.Divisor;
          q_next     = bus.Dividend;
          r_next     = '0;
          count_next = '0;
          if (bus.Divisor == '0) begin
            quotient_next  = DIVZERO_QUOTIENT;
            remainder_next = bus.Dividend;
            div_zero_next  = 1'b1;
            state_next     = DONE;
          end else begin
            div_zero_next  = 1'b0;
            state_next     = CALC;
          end
        end
      end
      CALC: begin
        r_next     = r_iter;
        q_next     = q_iter;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(ITER - 1)) begin
          quotient_next  = q_iter;
          remainder_next = r_iter;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (!bus.Run) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.Quotient  = quotient_reg;
  assign bus.Remainder = remainder_reg;
  assign bus.Done      = (state_reg == DONE);
  assign bus.DivZero   = div_zero_reg;

endmodule

// File: tb/tb_bit_divider_8.sv
// Directed bench for bit_divider_8: latency, results, divide-by-zero, reset and Run-hold behaviour.
module tb_bit_divider_8;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bit_divider_8_if dif ();

  bit_divider_8 dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (dif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a division and wait for Done; change_at>0 corrupts the inputs after that many edges.
  task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int exp_lat, input int change_at);
    int         lat;
    logic [7:0] prev_q;
    prev_q = dif.Quotient;
    @(negedge clk);
    dif.Dividend = dvd;
    dif.Divisor  = dvs;
    dif.Run      = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (dif.Done) break;
      if (lat == 4) begin
        check("q_hidden_in_calc", dif.Quotient, prev_q);
        check("dz_cleared_on_load", dif.DivZero, 1'b0);
      end
      if (lat == change_at) begin
        dif.Dividend = ~dvd;
        dif.Divisor  = dvs + 8'd1;
      end
    end
    check("latency", lat, exp_lat);
    check("done", dif.Done, 1'b1);
    check("quotient", dif.Quotient, eq);
    check("remainder", dif.Remainder, er);
    check("divzero", dif.DivZero, edz);
    $display("txn %0d / %0d -> q=%0d r=%0d dz=%0b lat=%0d", dvd, dvs,
             dif.Quotient, dif.Remainder, dif.DivZero, lat);
  endtask

  task automatic release_run(input logic [7:0] eq, input logic [7:0] er, input logic edz);
    @(negedge clk);
    dif.Run = 1'b0;
    @(posedge clk);
    #1;
    check("done_low_idle", dif.Done, 1'b0);
    check("q_hold_idle", dif.Quotient, eq);
    check("r_hold_idle", dif.Remainder, er);
    check("dz_hold_idle", dif.DivZero, edz);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    dif.Run      = 1'b0;
    dif.Dividend = '0;
    dif.Divisor  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", dif.Quotient, 8'd0);
    check("rst_remainder", dif.Remainder, 8'd0);
    check("rst_done", dif.Done, 1'b0);
    check("rst_divzero", dif.DivZero, 1'b0);
    rst = 1'b0;

    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 0);
    release_run(8'd28, 8'd4, 1'b0);
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 0);
    release_run(8'd255, 8'd0, 1'b0);
    run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, 0);
    release_run(8'd1, 8'd0, 1'b0);
    run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 0);
    release_run(8'd0, 8'd5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_long_remainder", dif.Remainder, 8'd5);
    run_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9, 0);
    release_run(8'd0, 8'd0, 1'b0);

    run_div(8'd100, 8'd0, 8'hFF, 8'd100, 1'b1, 1, 0);
    release_run(8'hFF, 8'd100, 1'b1);
    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 0);
    release_run(8'd28, 8'd4, 1'b0);

    // Reset at iteration 4, Run left high so the divider restarts afterwards.
    run_div(8'd13, 8'd5, 8'd2, 8'd3, 1'b0, 9, 0);
    release_run(8'd2, 8'd3, 1'b0);
    @(negedge clk);
    dif.Dividend = 8'd200;
    dif.Divisor  = 8'd7;
    dif.Run      = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_quotient", dif.Quotient, 8'd0);
    check("midrst_remainder", dif.Remainder, 8'd0);
    check("midrst_done", dif.Done, 1'b0);
    check("midrst_divzero", dif.DivZero, 1'b0);
    rst = 1'b0;
    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 0);

    // Run held through DONE with changing inputs: no restart.
    for (int i = 0; i < 20; i++) begin
      dif.Dividend = 8'(i * 17);
      dif.Divisor  = 8'(i);
      @(posedge clk);
      #1;
      check("hold_done", dif.Done, 1'b1);
      check("hold_quotient", dif.Quotient, 8'd28);
      check("hold_remainder", dif.Remainder, 8'd4);
    end
    release_run(8'd28, 8'd4, 1'b0);

    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 3);
    release_run(8'd28, 8'd4, 1'b0);

    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (b == 8'd0)
        run_div(a, b, 8'hFF, a, 1'b1, 1, 0);
      else
        run_div(a, b, a / b, a % b, 1'b0, 9, 0);
      @(negedge clk);
      dif.Run = 1'b0;
      @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
